// File: rtl/calc_pkg.sv
// Shared types for the round-robin calculator arbiter: ALU opcodes and arbiter FSM states.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_NEQ = 2'b11
    } calc_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU (add/sub/or/not-equal).
// Optional carry/borrow output when CALC_ARB_FLAGS_EN is defined.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  calc_op_t          op,
    output logic [DATA_W-1:0] result
`ifdef CALC_ARB_FLAGS_EN
    ,
    output logic              carry
`endif
);

    always_comb begin
        result = '0;
`ifdef CALC_ARB_FLAGS_EN
        carry  = 1'b0;
`endif
        case (op)
            OP_ADD: begin
`ifdef CALC_ARB_FLAGS_EN
                {carry, result} = {1'b0, a} + {1'b0, b};
`else
                result = a + b;
`endif
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow (a < b).
`ifdef CALC_ARB_FLAGS_EN
                {carry, result} = {1'b0, a} - {1'b0, b};
`else
                result = a - b;
`endif
            end
            OP_OR:   result = a | b;
            OP_NEQ:  result = DATA_W'(a != b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter sharing one registered calculator ALU among NUM_REQ requesters.
// Define CALC_ARB_FLAGS_EN to add the registered rsp_carry output.
module calc_rr_arbiter
    import calc_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
`ifdef CALC_ARB_FLAGS_EN
    ,
    output logic                      rsp_carry
`endif
);

    arb_state_t        state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [DATA_W-1:0] a_reg, b_reg;
    calc_op_t          op_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [DATA_W-1:0] alu_result;
`ifdef CALC_ARB_FLAGS_EN
    logic              alu_carry;
    logic              carry_reg;
`endif

    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];
    calc_op_t          op_arr [NUM_REQ];

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     idx_wide;
    logic [ID_W-1:0]   rr_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign a_arr[gi]  = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi]  = req_b[gi*DATA_W +: DATA_W];
            assign op_arr[gi] = calc_op_t'(req_op[gi*2 +: 2]);
            // Ready is forced low while clear is held so reset state shows no grant.
            assign req_ready[gi] = (state_reg == S_IDLE) && !clear && grant_found
                                   && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Scan from rr_ptr upward with wraparound; first valid index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_wide    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_wide = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (idx_wide >= (ID_W+1)'(NUM_REQ)) begin
                idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[idx_wide[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_wide[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        rsp_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: state_next = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign rr_ptr_next = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);

    calc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (alu_result)
`ifdef CALC_ARB_FLAGS_EN
        ,
        .carry  (alu_carry)
`endif
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= OP_ADD;
            rsp_data_reg <= '0;
`ifdef CALC_ARB_FLAGS_EN
            carry_reg    <= 1'b0;
`endif
        end else begin
            if (state_reg == S_IDLE && grant_found) begin
                a_reg  <= a_arr[grant_idx];
                b_reg  <= b_arr[grant_idx];
                op_reg <= op_arr[grant_idx];
                id_reg <= grant_idx;
            end
            if (state_reg == S_EXEC) begin
                rsp_data_reg <= alu_result;
`ifdef CALC_ARB_FLAGS_EN
                carry_reg    <= alu_carry;
`endif
            end
            if (state_reg == S_RESP && rsp_ready) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_id   = id_reg;
`ifdef CALC_ARB_FLAGS_EN
    assign rsp_carry = carry_reg;
`endif

endmodule

// File: tb/tb_calc_rr_arbiter.sv
// Directed testbench for calc_rr_arbiter: single ops, round-robin order, back-pressure, clear, pointer update.
module tb_calc_rr_arbiter;

    logic        clock;
    logic        clear;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef CALC_ARB_FLAGS_EN
    logic        rsp_carry;
`endif

    int vectors     = 0;
    int miscompares = 0;

    calc_rr_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (4)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef CALC_ARB_FLAGS_EN
        ,
        .rsp_carry (rsp_carry)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
        req_op[i*2 +: 2] = op;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        req_valid = 4'b1111;
        #12;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        vectors++; if (rsp_data !== 4'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
`ifdef CALC_ARB_FLAGS_EN
        vectors++; if (rsp_carry !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_carry: got %0b expected 0", rsp_carry); end
`endif
        req_valid = 4'b0000;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_single_ops();
        int         t_idx [5];
        logic [3:0] t_a   [5];
        logic [3:0] t_b   [5];
        logic [1:0] t_op  [5];
        logic [3:0] t_exp [5];
        logic       t_cy  [5];
        t_idx = '{0, 1, 2, 2, 1};
        t_a   = '{4'd7, 4'd3, 4'd9, 4'd9, 4'd9};
        t_b   = '{4'd5, 4'd5, 4'd9, 4'd8, 4'd8};
        t_op  = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
        t_exp = '{4'd12, 4'd14, 4'd0, 4'd1, 4'd1};
        t_cy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 5; v++) begin
            @(negedge clock);
            set_req(t_idx[v], t_a[v], t_b[v], t_op[v]);
            req_valid = 4'(1 << t_idx[v]);
            #1;
            vectors++; if (req_ready !== 4'(1 << t_idx[v])) begin miscompares++; $display("FAIL single_grant[%0d]: got %b expected %b", v, req_ready, 4'(1 << t_idx[v])); end
            @(negedge clock);
            req_valid = 4'b0000;
            #1;
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_exec_valid[%0d]: got %0b expected 0", v, rsp_valid); end
            @(negedge clock);
            #1;
            $display("single op %0d: id=%0d data=%0h valid=%0b", v, rsp_id, rsp_data, rsp_valid);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid[%0d]: got %0b expected 1", v, rsp_valid); end
            vectors++; if (rsp_data !== t_exp[v]) begin miscompares++; $display("FAIL single_rsp_data[%0d]: got %0h expected %0h", v, rsp_data, t_exp[v]); end
            vectors++; if (rsp_id !== 2'(t_idx[v])) begin miscompares++; $display("FAIL single_rsp_id[%0d]: got %0d expected %0d", v, rsp_id, t_idx[v]); end
`ifdef CALC_ARB_FLAGS_EN
            vectors++; if (rsp_carry !== t_cy[v]) begin miscompares++; $display("FAIL single_rsp_carry[%0d]: got %0b expected %0b", v, rsp_carry, t_cy[v]); end
`else
            if (t_cy[v] === 1'bx) $display("carry table entry %0d undefined", v);
`endif
        end
    endtask

    task automatic test_round_robin();
        int         order [5];
        logic [3:0] exp_data;
        order = '{0, 1, 2, 3, 0};
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd1, 2'b00);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_data = 4'(order[g] + 2);
            #1;
            vectors++; if (req_ready !== 4'(1 << order[g])) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", g, req_ready, 4'(1 << order[g])); end
            @(negedge clock);
            #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rr_exec_ready[%0d]: got %b expected 0000", g, req_ready); end
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rr_exec_valid[%0d]: got %0b expected 0", g, rsp_valid); end
            @(negedge clock);
            #1;
            $display("rr grant %0d: id=%0d data=%0h", g, rsp_id, rsp_data);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rr_rsp_valid[%0d]: got %0b expected 1", g, rsp_valid); end
            vectors++; if (rsp_id !== 2'(order[g])) begin miscompares++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", g, rsp_id, order[g]); end
            vectors++; if (rsp_data !== exp_data) begin miscompares++; $display("FAIL rr_rsp_data[%0d]: got %0h expected %0h", g, rsp_data, exp_data); end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rr_resp_ready[%0d]: got %b expected 0000", g, req_ready); end
            @(negedge clock);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure();
        @(negedge clock);
        rsp_ready = 1'b0;
        set_req(1, 4'd6, 4'd3, 2'b00);
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
        @(negedge clock);
        set_req(0, 4'd1, 4'd1, 2'b00);
        set_req(2, 4'd2, 4'd2, 2'b00);
        set_req(3, 4'd3, 4'd3, 2'b00);
        req_valid = 4'b1101;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_exec_ready: got %b expected 0000", req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            $display("back-pressure cycle %0d: valid=%0b id=%0d data=%0h", c, rsp_valid, rsp_id, rsp_data);
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %0b expected 1", c, rsp_valid); end
            vectors++; if (rsp_data !== 4'd9) begin miscompares++; $display("FAIL bp_data[%0d]: got %0h expected 9", c, rsp_data); end
            vectors++; if (rsp_id !== 2'd1) begin miscompares++; $display("FAIL bp_id[%0d]: got %0d expected 1", c, rsp_id); end
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %0b expected 0", rsp_valid); end
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_next_grant: got %b expected 0100", req_ready); end
        req_valid = 4'b0000;
    endtask

    task automatic test_clear_midop();
        @(negedge clock);
        set_req(3, 4'd1, 4'd1, 2'b00);
        req_valid = 4'b1000;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL clr_grant3: got %b expected 1000", req_ready); end
        @(negedge clock);
        set_req(0, 4'd2, 4'd3, 2'b00);
        set_req(1, 4'd4, 4'd4, 2'b00);
        set_req(2, 4'd5, 4'd5, 2'b00);
        req_valid = 4'b1111;
        #1;
        clear = 1'b1;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid_now: got %0b expected 0", rsp_valid); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL clr_ready_now: got %b expected 0000", req_ready); end
        @(negedge clock);
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL clr_no_rsp: got %0b expected 0", rsp_valid); end
        clear = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL clr_restart_grant: got %b expected 0001", req_ready); end
        @(negedge clock);
        req_valid = 4'b0000;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL clr_exec_valid: got %0b expected 0", rsp_valid); end
        @(negedge clock);
        #1;
        $display("after clear: id=%0d data=%0h valid=%0b", rsp_id, rsp_data, rsp_valid);
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL clr_rsp_valid: got %0b expected 1", rsp_valid); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL clr_rsp_id: got %0d expected 0", rsp_id); end
        vectors++; if (rsp_data !== 4'd5) begin miscompares++; $display("FAIL clr_rsp_data: got %0h expected 5", rsp_data); end
    endtask

    task automatic test_or_pointer();
        @(negedge clock);
        set_req(2, 4'b1010, 4'b0101, 2'b10);
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL or_grant: got %b expected 0100", req_ready); end
        @(negedge clock);
        req_valid = 4'b0000;
        @(negedge clock);
        #1;
        $display("or op: id=%0d data=%0h", rsp_id, rsp_data);
        vectors++; if (rsp_data !== 4'hF) begin miscompares++; $display("FAIL or_data: got %0h expected f", rsp_data); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("FAIL or_id: got %0d expected 2", rsp_id); end
`ifdef CALC_ARB_FLAGS_EN
        vectors++; if (rsp_carry !== 1'b0) begin miscompares++; $display("FAIL or_carry: got %0b expected 0", rsp_carry); end
`endif
        @(negedge clock);
        set_req(0, 4'd8, 4'd8, 2'b00);
        set_req(3, 4'd1, 4'd1, 2'b00);
        req_valid = 4'b1001;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL ptr_grant3: got %b expected 1000", req_ready); end
        @(negedge clock);
        req_valid = 4'b0000;
        @(negedge clock);
        #1;
        $display("ptr op: id=%0d data=%0h", rsp_id, rsp_data);
        vectors++; if (rsp_id !== 2'd3) begin miscompares++; $display("FAIL ptr_rsp_id: got %0d expected 3", rsp_id); end
        vectors++; if (rsp_data !== 4'd2) begin miscompares++; $display("FAIL ptr_rsp_data: got %0h expected 2", rsp_data); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_round_robin();
        test_back_pressure();
        test_clear_midop();
        test_or_pointer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
